// File: rtl/alu.sv
// rtl/alu.sv - registered 32-bit RV32I integer ALU with one-cycle latency
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [3:0]  alu_cmd,
  output logic [31:0] out,
  output logic        out_valid
);

  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_SUB  = 4'd1,
    CMD_SLT  = 4'd2,
    CMD_SLTU = 4'd3,
    CMD_AND  = 4'd4,
    CMD_OR   = 4'd5,
    CMD_XOR  = 4'd6,
    CMD_SLL  = 4'd7,
    CMD_SRL  = 4'd8,
    CMD_SRA  = 4'd9
  } cmd_e;

  logic [4:0]  shamt;
  logic [31:0] result;

  assign shamt = rs2[4:0];

  always_comb begin
    result = 32'h0000_0000;
    case (alu_cmd)
      CMD_ADD:  result = rs1 + rs2;
      CMD_SUB:  result = rs1 - rs2;
      CMD_SLT:  result = {31'd0, $signed(rs1) < $signed(rs2)};
      CMD_SLTU: result = {31'd0, rs1 < rs2};
      CMD_AND:  result = rs1 & rs2;
      CMD_OR:   result = rs1 | rs2;
      CMD_XOR:  result = rs1 ^ rs2;
      CMD_SLL:  result = rs1 << shamt;
      CMD_SRL:  result = rs1 >> shamt;
      CMD_SRA:  result = $unsigned($signed(rs1) >>> shamt);
      default:  result = 32'h0000_0000;  // reserved commands still complete with zero
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= result;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking testbench for alu
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  alu_cmd;
  logic [31:0] out;
  logic        out_valid;

  int checks;
  int errors;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .alu_cmd   (alu_cmd),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    in_valid = v;
    rs1      = a;
    rs2      = b;
    alu_cmd  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] exp);
    drive(1'b1, a, b, c);
    checks++;
    if (out !== exp || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: out=%h out_valid=%b expected out=%h out_valid=1", name, out, out_valid, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'h1, 4'd0);
    drive(1'b0, 32'h0, 32'h0, 4'd0);
    checks++;
    if (out !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h out_valid=%b expected out=00000000 out_valid=0", out, out_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_shifts();
    one_op("sra_sign_fill", 32'h8000_0000, 32'h0000_0008, 4'd9, 32'hFF80_0000);
    one_op("srl_zero_fill", 32'h8000_0000, 32'h0000_0008, 4'd8, 32'h0080_0000);
    one_op("sll_shamt_mask", 32'h0000_0001, 32'h0000_0023, 4'd7, 32'h0000_0008);
    one_op("sra_positive", 32'h4000_0000, 32'h0000_0004, 4'd9, 32'h0400_0000);
    one_op("sll_shift_zero", 32'hDEAD_BEEF, 32'hFFFF_FFE0, 4'd7, 32'hDEAD_BEEF);
    one_op("sra_shift_31", 32'h8000_0000, 32'h0000_001F, 4'd9, 32'hFFFF_FFFF);
    one_op("srl_shift_31", 32'h8000_0000, 32'h0000_001F, 4'd8, 32'h0000_0001);
  endtask

  task automatic test_arith();
    one_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 32'h0000_0000);
    one_op("sub_wrap", 32'h0000_0000, 32'h0000_0001, 4'd1, 32'hFFFF_FFFF);
    one_op("add_plain", 32'h0000_0007, 32'h0000_0005, 4'd0, 32'h0000_000C);
    one_op("sub_plain", 32'h0000_0010, 32'h0000_0003, 4'd1, 32'h0000_000D);
  endtask

  task automatic test_compare();
    one_op("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 4'd2, 32'h0000_0001);
    one_op("sltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0000_0000);
    one_op("slt_equal", 32'h0000_0005, 32'h0000_0005, 4'd2, 32'h0000_0000);
    one_op("sltu_equal", 32'h0000_0005, 32'h0000_0005, 4'd3, 32'h0000_0000);
    one_op("slt_pos_gt_neg", 32'h0000_0001, 32'h8000_0000, 4'd2, 32'h0000_0000);
    one_op("sltu_small", 32'h0000_0001, 32'h8000_0000, 4'd3, 32'h0000_0001);
  endtask

  task automatic test_logic();
    one_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4, 32'hF000_F000);
    one_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 32'hFFF0_FFF0);
    one_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 32'h0FF0_0FF0);
    one_op("reserved_12", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd12, 32'h0000_0000);
    one_op("reserved_15", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0000_0000);
  endtask

  task automatic test_back_to_back();
    one_op("b2b_first", 32'h0000_0002, 32'h0000_0003, 4'd0, 32'h0000_0005);
    one_op("b2b_second", 32'h0000_0009, 32'h0000_0004, 4'd1, 32'h0000_0005 + 32'd0);
    one_op("b2b_third", 32'h0000_00AA, 32'h0000_000F, 4'd4, 32'h0000_000A);
    drive(1'b0, 32'h1111_1111, 32'h2222_2222, 4'd0);
    checks++;
    if (out !== 32'h0000_000A || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold: out=%h out_valid=%b expected out=0000000a out_valid=0", out, out_valid);
    end
    drive(1'b0, 32'h3333_3333, 32'h1, 4'd0);
    checks++;
    if (out !== 32'h0000_000A || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold2: out=%h out_valid=%b expected out=0000000a out_valid=0", out, out_valid);
    end
    one_op("after_gap", 32'h0000_0100, 32'h0000_0001, 4'd0, 32'h0000_0101);
  endtask

  task automatic test_reset_mid_op();
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0040, 32'h0000_0002, 4'd0);
    checks++;
    if (out !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: out=%h out_valid=%b expected out=00000000 out_valid=0", out, out_valid);
    end
    rst_n = 1'b1;
    one_op("first_after_reset", 32'h0000_0040, 32'h0000_0002, 4'd0, 32'h0000_0042);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    rs1      = '0;
    rs2      = '0;
    alu_cmd  = '0;
    test_reset();
    test_shifts();
    test_arith();
    test_compare();
    test_logic();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer ALU for the Hubris RV32I core's execute stage. It computes one of ten RV32I arithmetic, logic, compare and shift operations on two 32-bit operands. The result is captured into an output register on the rising clock edge, one cycle after the operands are presented. Operand selection (register or immediate) happens upstream; the block only sees `rs1`, `rs2` and a 4-bit command.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  operands and command valid this cycle.
- `rs1`  in  32  operand A.
- `rs2`  in  32  operand B; bits [4:0] are the shift amount for shift commands.
- `alu_cmd`  in  4  operation select.
- `out`  out  32  registered result.
- `out_valid`  out  1  `out` holds the result of the previous cycle's accepted operation.

## Operation
- Command encoding:
  - 0 ADD: rs1+rs2 mod 2^32.
  - 1 SUB: rs1−rs2 mod 2^32.
  - 2 SLT: 1 if signed rs1 < signed rs2, else 0.
  - 3 SLTU: 1 if unsigned rs1 < unsigned rs2, else 0.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 SLL: rs1 << rs2[4:0].
  - 8 SRL: logical right shift, zero fill.
  - 9 SRA: arithmetic right shift, fill with rs1[31].
- Commands 10–15 are reserved and produce result 0x0000_0000. They are still accepted and raise `out_valid`.
- Arithmetic rules:
  - ADD and SUB wrap; no carry or overflow outputs.
  - SLT and SLTU results are zero-extended to 32 bits.
  - Shifts ignore rs2[31:5]. A shift by 0 returns rs1 unchanged.
- Result computation is purely combinational from `rs1`, `rs2`, `alu_cmd`. Only the output stage is registered.
- `out` hold rule: when `in_valid`=0, `out` keeps its previous value.
- `out_valid` follows `in_valid` with one cycle of delay.

## Timing
- Reset: at a rising `clk` with `rst_n`=0, `out` ← 0x0000_0000 and `out_valid` ← 0. Reset has priority over `in_valid`.
- Reset mid-operation: an operation presented in the same cycle as reset is discarded.
- Latency is exactly 1 cycle. Operands sampled at edge N with `in_valid`=1 appear on `out` with `out_valid`=1 after edge N.
- Throughput is one operation per cycle; back-to-back valid inputs produce back-to-back results.
- There is no backpressure: the consumer must take `out` in the cycle `out_valid`=1.
- When `in_valid`=0 at an edge, `out_valid` ← 0 and `out` holds its previous value.
- The first result is produced at the first edge after `rst_n` deasserts with `in_valid`=1.

## Test plan
- SRA sign fill: rs1=0x8000_0000, rs2=8, cmd=9 → `out`=0xFF80_0000 one cycle later, `out_valid`=1.
- SRL/SLL, same rs1 and rs2=8:
  - cmd=8 → 0x0080_0000.
  - rs1=0x0000_0001, rs2=0x0000_0023 (shamt 3), cmd=7 → 0x0000_0008.
- Add/sub wrap:
  - 0xFFFF_FFFF + 1 (cmd 0) → 0x0000_0000.
  - 0 − 1 (cmd 1) → 0xFFFF_FFFF.
- Compares with rs1=0xFFFF_FFFF, rs2=1:
  - SLT (cmd 2) → 1.
  - SLTU (cmd 3) → 0.
  - rs1=rs2=5 → both 0.
- Logic and reserved with rs1=0xF0F0_F0F0, rs2=0xFF00_FF00:
  - AND → 0xF000_F000.
  - OR → 0xFFF0_FFF0.
  - XOR → 0x0FF0_0FF0.
  - cmd=12 → 0x0000_0000.
- Pipeline and reset:
  - Back-to-back valid ops each appear one cycle later.
  - A `in_valid`=0 gap holds `out` and drops `out_valid`.
  - `rst_n`=0 concurrent with a valid op gives `out`=0 and `out_valid`=0 next cycle.
